operand_fetch: RTL

//  Decode-side reader of the writeback interface (wb_rw/wb_dest/wb_data).

---
 rtl/operand_fetch.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode-side operand fetch with pending-write interlock
// Holds the register file, stalls RAW/WAW hazards and registers operands for execute.
module operand_fetch #(
  parameter int DW   = 20,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] ins,
  input  logic          wb_rw,
  input  logic [3:0]    wb_dest,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_ins,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [3:0]    out_dest,
  output logic          out_rtype,
  output logic          out_lw
);

  localparam int AW = 4;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LW    = 4'h1;
  localparam logic [3:0] OP_SW    = 4'h2;

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] clr_vec, set_vec, eff;

  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_ins_q, out_ins_d;
  logic [DW-1:0]   out_a_q, out_a_d;
  logic [DW-1:0]   out_b_q, out_b_d;
  logic [AW-1:0]   out_dest_q, out_dest_d;
  logic            out_rtype_q, out_rtype_d;
  logic            out_lw_q, out_lw_d;

  logic [3:0]      op;
  logic [AW-1:0]   rs, rt, rd, dest;
  logic            reads_rt;
  logic            hazard;
  logic            accept;
  logic [DW-1:0]   rs_val, rt_val;

  always_comb begin
    op = ins[19:16];
    rs = ins[15:12];
    rt = ins[11:8];
    rd = ins[7:4];
    reads_rt = (op == OP_RTYPE) || (op == OP_SW);
    case (op)
      OP_RTYPE: dest = rd;
      OP_SW:    dest = '0;
      default:  dest = rt;
    endcase
  end

  // Same-cycle writeback bypasses the array so a retiring producer unblocks its consumer.
  always_comb begin
    rs_val = regs_q[rs];
    if (rs == '0) begin
      rs_val = '0;
    end else if (wb_rw && (wb_dest == rs)) begin
      rs_val = wb_data;
    end
    rt_val = regs_q[rt];
    if (rt == '0) begin
      rt_val = '0;
    end else if (wb_rw && (wb_dest == rt)) begin
      rt_val = wb_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      clr_vec[i] = wb_rw && (wb_dest == AW'(i));
    end
    eff    = pend_q & ~clr_vec;
    eff[0] = 1'b0;
    hazard = in_valid && (eff[rs] || (reads_rt && eff[rt]) || eff[dest]);
  end

  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Set is OR-ed after the clear so a new claim wins over a same-index retire.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      set_vec[i] = accept && (dest != '0) && (dest == AW'(i));
    end
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_rw && (wb_dest != '0)) begin
      regs_d[wb_dest] = wb_data;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_ins_d   = out_ins_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_dest_d  = out_dest_q;
    out_rtype_d = out_rtype_q;
    out_lw_d    = out_lw_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_ins_d   = ins;
      out_a_d     = rs_val;
      out_b_d     = rt_val;
      out_dest_d  = dest;
      out_rtype_d = (op == OP_RTYPE);
      out_lw_d    = (op == OP_LW);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_ins_q   <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_dest_q  <= '0;
      out_rtype_q <= 1'b0;
      out_lw_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_ins_q   <= out_ins_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_dest_q  <= out_dest_d;
      out_rtype_q <= out_rtype_d;
      out_lw_q    <= out_lw_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ins   = out_ins_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_dest  = out_dest_q;
  assign out_rtype = out_rtype_q;
  assign out_lw    = out_lw_q;

endmodule
